// File: rtl/text_overlay_ctrl.sv
// HUD/menu text sequencer: latches score/lives per frame, runs blink/flash/reveal timers per phase,
// and gates + colour-muxes the text layer flags into one RGB overlay registered 1 clk after text_on_i.
module text_overlay_ctrl #(
  parameter int BLINK_FRAMES  = 30,
  parameter int FLASH_FRAMES  = 48,
  parameter int FLASH_HALF    = 4,
  parameter int REVEAL_FRAMES = 60
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        frame_tick_i,
  input  logic [1:0]  game_state_i,
  input  logic [7:0]  score_in_i,
  input  logic [1:0]  lives_in_i,
  input  logic [18:0] text_on_i,
  output logic [7:0]  score_val_o,
  output logic [1:0]  lives_o,
  output logic [11:0] text_rgb_o,
  output logic        text_valid_o
);

  typedef enum logic [2:0] {
    ST_TITLE     = 3'd0,
    ST_HOWTO     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_OVER_WAIT = 3'd3,
    ST_OVER_SHOW = 3'd4
  } state_e;

  localparam logic [7:0]  BLINK_LAST  = 8'(BLINK_FRAMES - 1);
  localparam logic [7:0]  REVEAL_LAST = 8'(REVEAL_FRAMES - 1);
  localparam logic [7:0]  FLASH_INIT  = 8'(FLASH_FRAMES);
  localparam logic [7:0]  FLASH_DIV   = 8'(FLASH_HALF);
  localparam logic [11:0] RGB_WHITE   = 12'hFFF;
  localparam logic [11:0] RGB_RED     = 12'hF00;
  localparam logic [11:0] RGB_GREEN   = 12'h0F0;

  state_e      state_q, state_d;
  logic [7:0]  blink_cnt_q, blink_cnt_d;
  logic        blink_phase_q, blink_phase_d;
  logic [7:0]  flash_cnt_q, flash_cnt_d;
  logic [7:0]  reveal_cnt_q, reveal_cnt_d;
  logic [7:0]  score_val_q, score_val_d;
  logic [1:0]  lives_q, lives_d;
  logic [11:0] text_rgb_q, text_rgb_d;
  logic        text_valid_q, text_valid_d;

  // text_on_i fields, right-aligned; the top two bits carry no flag
  logic       start_on, howto_on, score_txt_on, score_num_on, hp_on, hearts_on;
  logic [5:0] lines_on;
  logic       green_on, red_on, go_on, fsc_txt_on, fsc_num_on;
  logic       unused_txt;

  assign start_on     = text_on_i[16];
  assign howto_on     = text_on_i[15];
  assign score_txt_on = text_on_i[14];
  assign score_num_on = text_on_i[13];
  assign hp_on        = text_on_i[12];
  assign hearts_on    = text_on_i[11];
  assign lines_on     = text_on_i[10:5];
  assign green_on     = text_on_i[4];
  assign red_on       = text_on_i[3];
  assign go_on        = text_on_i[2];
  assign fsc_txt_on   = text_on_i[1];
  assign fsc_num_on   = text_on_i[0];
  assign unused_txt   = ^text_on_i[18:17];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_TITLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (frame_tick_i) begin
      case (game_state_i)
        2'd0:    state_d = ST_TITLE;
        2'd1:    state_d = ST_HOWTO;
        2'd2:    state_d = ST_PLAY;
        default: begin
          case (state_q)
            ST_OVER_WAIT: state_d = (reveal_cnt_q == REVEAL_LAST) ? ST_OVER_SHOW : ST_OVER_WAIT;
            ST_OVER_SHOW: state_d = ST_OVER_SHOW;
            default:      state_d = ST_OVER_WAIT;
          endcase
        end
      endcase
    end
  end

  // Phase gating of the raw flags
  logic start_g, howto_g, score_txt_g, score_num_g, hp_g, hearts_g;
  logic lines_g, green_g, red_g, go_g, fsc_txt_g, fsc_num_g;

  always_comb begin
    start_g     = 1'b0;
    howto_g     = 1'b0;
    score_txt_g = 1'b0;
    score_num_g = 1'b0;
    hp_g        = 1'b0;
    hearts_g    = 1'b0;
    lines_g     = 1'b0;
    green_g     = 1'b0;
    red_g       = 1'b0;
    go_g        = 1'b0;
    fsc_txt_g   = 1'b0;
    fsc_num_g   = 1'b0;
    case (state_q)
      ST_TITLE: start_g = start_on & blink_phase_q;
      ST_HOWTO: begin
        howto_g = howto_on;
        lines_g = |lines_on;
        green_g = green_on;
        red_g   = red_on;
      end
      ST_PLAY: begin
        score_txt_g = score_txt_on;
        score_num_g = score_num_on;
        hp_g        = hp_on;
        hearts_g    = hearts_on;
      end
      ST_OVER_WAIT: go_g = go_on;
      ST_OVER_SHOW: begin
        go_g      = go_on;
        fsc_txt_g = fsc_txt_on;
        fsc_num_g = fsc_num_on;
      end
      default: ;
    endcase
  end

  logic flash_red;
  assign flash_red = ((flash_cnt_q / FLASH_DIV) & 8'd1) != 8'd0;

  always_comb begin
    text_valid_d = start_g | howto_g | score_txt_g | score_num_g | hp_g | hearts_g |
                   lines_g | green_g | red_g | go_g | fsc_txt_g | fsc_num_g;
    text_rgb_d   = 12'h000;
    if (hearts_g) begin
      text_rgb_d = (flash_cnt_q != 8'd0 && !flash_red) ? RGB_WHITE : RGB_RED;
    end else if (red_g) begin
      text_rgb_d = RGB_RED;
    end else if (green_g) begin
      text_rgb_d = RGB_GREEN;
    end else if (go_g) begin
      text_rgb_d = RGB_RED;
    end else if (text_valid_d) begin
      text_rgb_d = RGB_WHITE;
    end
  end

  // Frame-rate timers and tear-free sampling: everything moves only on frame_tick_i
  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    flash_cnt_d   = flash_cnt_q;
    reveal_cnt_d  = reveal_cnt_q;
    score_val_d   = score_val_q;
    lives_d       = lives_q;
    if (frame_tick_i) begin
      score_val_d = score_in_i;
      lives_d     = lives_in_i;

      if (state_d == ST_TITLE) begin
        if (state_q != ST_TITLE) begin
          blink_cnt_d   = 8'd0;
          blink_phase_d = 1'b1;
        end else if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_d   = 8'd0;
          blink_phase_d = ~blink_phase_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 8'd1;
        end
      end

      if (state_d != ST_PLAY) begin
        flash_cnt_d = 8'd0;
      end else if (lives_in_i < lives_q) begin
        flash_cnt_d = FLASH_INIT;
      end else if (flash_cnt_q != 8'd0) begin
        flash_cnt_d = flash_cnt_q - 8'd1;
      end

      if (state_q == ST_OVER_WAIT &&
          (state_d == ST_OVER_WAIT || state_d == ST_OVER_SHOW)) begin
        reveal_cnt_d = reveal_cnt_q + 8'd1;
      end else if (state_q == ST_OVER_SHOW && state_d == ST_OVER_SHOW) begin
        reveal_cnt_d = reveal_cnt_q;
      end else begin
        reveal_cnt_d = 8'd0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      blink_cnt_q   <= 8'd0;
      blink_phase_q <= 1'b1;
      flash_cnt_q   <= 8'd0;
      reveal_cnt_q  <= 8'd0;
      score_val_q   <= 8'd0;
      lives_q       <= 2'd0;
      text_rgb_q    <= 12'h000;
      text_valid_q  <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      flash_cnt_q   <= flash_cnt_d;
      reveal_cnt_q  <= reveal_cnt_d;
      score_val_q   <= score_val_d;
      lives_q       <= lives_d;
      text_rgb_q    <= text_rgb_d;
      text_valid_q  <= text_valid_d;
    end
  end

  // Counters are 8 bit with no saturation, so frame parameters must fit
  always_ff @(posedge clk_i) begin
    assert (BLINK_FRAMES >= 1 && BLINK_FRAMES < 256 &&
            FLASH_FRAMES >= 1 && FLASH_FRAMES < 256 &&
            FLASH_HALF >= 1 && FLASH_HALF < 256 &&
            REVEAL_FRAMES >= 1 && REVEAL_FRAMES < 256);
  end

  assign score_val_o  = score_val_q;
  assign lives_o      = lives_q;
  assign text_rgb_o   = text_rgb_q;
  assign text_valid_o = text_valid_q;

endmodule

// File: tb/tb_text_overlay_ctrl.sv
// Randomized bench for text_overlay_ctrl against a frame-level behavioural model.
module tb_text_overlay_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick;
  logic [1:0]  game_state;
  logic [7:0]  score_in;
  logic [1:0]  lives_in;
  logic [18:0] text_on;
  logic [7:0]  score_val;
  logic [1:0]  lives;
  logic [11:0] text_rgb;
  logic        text_valid;

  always #5 clk = ~clk;

  text_overlay_ctrl dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .frame_tick_i (frame_tick),
    .game_state_i (game_state),
    .score_in_i   (score_in),
    .lives_in_i   (lives_in),
    .text_on_i    (text_on),
    .score_val_o  (score_val),
    .lives_o      (lives),
    .text_rgb_o   (text_rgb),
    .text_valid_o (text_valid)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: phase as game_state value, plus frames spent in the current phase
  int m_phase, m_title_n, m_over_n, m_flash, m_score, m_lives;
  logic [7:0] cur_sc;
  logic [1:0] cur_lv;

  task automatic model_reset();
    m_phase = 0; m_title_n = 0; m_over_n = 0; m_flash = 0; m_score = 0; m_lives = 0;
  endtask

  function automatic logic [12:0] predict(input logic [18:0] t);
    logic hearts, red, green, go, other, v;
    logic [11:0] rgb;
    hearts = 0; red = 0; green = 0; go = 0; other = 0;
    case (m_phase)
      0: other = t[16] && ((m_title_n / 30) % 2 == 0);
      1: begin other = t[15] | (|t[10:5]); green = t[4]; red = t[3]; end
      2: begin hearts = t[11]; other = t[14] | t[13] | t[12]; end
      default: begin go = t[2]; if (m_over_n >= 60) other = t[1] | t[0]; end
    endcase
    v = hearts | red | green | go | other;
    if (hearts)     rgb = (m_flash > 0 && (m_flash / 4) % 2 == 0) ? 12'hFFF : 12'hF00;
    else if (red)   rgb = 12'hF00;
    else if (green) rgb = 12'h0F0;
    else if (go)    rgb = 12'hF00;
    else if (v)     rgb = 12'hFFF;
    else            rgb = 12'h000;
    return {v, rgb};
  endfunction

  task automatic step(input logic tick, input logic [1:0] gs, input logic [7:0] sc,
                      input logic [1:0] lv, input logic [18:0] ton);
    logic [12:0] e;
    frame_tick = tick; game_state = gs; score_in = sc; lives_in = lv; text_on = ton;
    e = predict(ton);
    if (tick) begin
      if (gs == 2'd0) m_title_n = (m_phase == 0) ? m_title_n + 1 : 0;
      if (gs == 2'd3) m_over_n  = (m_phase == 3) ? m_over_n + 1 : 0;
      if (gs == 2'd2) m_flash = (int'(lv) < m_lives) ? 48 : ((m_flash > 0) ? m_flash - 1 : 0);
      else            m_flash = 0;
      m_phase = int'(gs); m_score = int'(sc); m_lives = int'(lv);
    end
    @(posedge clk); #1;
    chk("text_rgb", 32'(text_rgb), 32'(e[11:0]));
    chk("text_valid", 32'(text_valid), 32'(e[12]));
    chk("score_val", 32'(score_val), 32'(m_score));
    chk("lives", 32'(lives), 32'(m_lives));
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0; frame_tick = 1'b1; text_on = '1; game_state = 2'd2;
    score_in = 8'hA5; lives_in = 2'd3;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("rst_rgb", 32'(text_rgb), 32'h0);
      chk("rst_valid", 32'(text_valid), 32'h0);
      chk("rst_score", 32'(score_val), 32'h0);
      chk("rst_lives", 32'(lives), 32'h0);
    end
    model_reset();
    rst_n = 1'b1; frame_tick = 1'b0;
  endtask

  task automatic run_segment(input logic [1:0] gs, input int frames);
    for (int f = 0; f < frames; f++) begin
      int gap;
      gap = $urandom_range(1, 4);
      for (int c = 0; c < gap; c++) begin
        if ($urandom_range(0, 2) == 0) cur_sc = 8'($urandom);
        step(1'b0, gs, cur_sc, 2'($urandom), 19'($urandom & $urandom));
      end
      if ($urandom_range(0, 5) == 0) cur_lv = 2'($urandom_range(0, 3));
      step(1'b1, gs, cur_sc, cur_lv, 19'($urandom & $urandom));
    end
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; game_state = 2'd0;
    score_in = 8'd0; lives_in = 2'd0; text_on = '0;
    cur_sc = 8'd5; cur_lv = 2'd3;
    model_reset();
    do_reset(3);

    run_segment(2'd0, 125);
    run_segment(2'd1, 8);
    cur_lv = 2'd3;
    run_segment(2'd2, 70);
    run_segment(2'd3, 70);
    run_segment(2'd0, 35);
    run_segment(2'd2, 60);
    run_segment(2'd3, 20);
    run_segment(2'd2, 50);

    // Reset in the middle of a frame
    do_reset(1);

    for (int s = 0; s < 14; s++) begin
      run_segment(2'($urandom_range(0, 3)), $urandom_range(1, 70));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
